// File: rtl/cbus_axi_bridge_pkg.sv
// Shared types for the cache-bus to AXI3 bridge: cache bus payloads, AXI3 channel bundles, FSM states.
package cbus_axi_bridge_pkg;

  localparam int unsigned ADDR_W  = 32;
  localparam int unsigned DATA_W  = 32;
  localparam int unsigned STRB_W  = 4;
  localparam int unsigned LEN_W   = 4;
  localparam int unsigned SIZE_W  = 3;
  localparam int unsigned BURST_W = 2;
  localparam int unsigned RESP_W  = 2;
  localparam int unsigned ID_W    = 4;

  typedef struct packed {
    logic               valid;
    logic               is_write;
    logic [SIZE_W-1:0]  size;
    logic [ADDR_W-1:0]  addr;
    logic [STRB_W-1:0]  strobe;
    logic [DATA_W-1:0]  data;
    logic [LEN_W-1:0]   len;
    logic [BURST_W-1:0] burst;
  } cbus_req_t;

  typedef struct packed {
    logic              ready;
    logic              last;
    logic [DATA_W-1:0] data;
  } cbus_resp_t;

  typedef struct packed {
    logic               arvalid;
    logic [ID_W-1:0]    arid;
    logic [ADDR_W-1:0]  araddr;
    logic [LEN_W-1:0]   arlen;
    logic [SIZE_W-1:0]  arsize;
    logic [BURST_W-1:0] arburst;
    logic               awvalid;
    logic [ID_W-1:0]    awid;
    logic [ADDR_W-1:0]  awaddr;
    logic [LEN_W-1:0]   awlen;
    logic [SIZE_W-1:0]  awsize;
    logic [BURST_W-1:0] awburst;
    logic               wvalid;
    logic [ID_W-1:0]    wid;
    logic [DATA_W-1:0]  wdata;
    logic [STRB_W-1:0]  wstrb;
    logic               wlast;
    logic               rready;
    logic               bready;
  } axi_req_t;

  typedef struct packed {
    logic              arready;
    logic              awready;
    logic              wready;
    logic              rvalid;
    logic [ID_W-1:0]   rid;
    logic [DATA_W-1:0] rdata;
    logic [RESP_W-1:0] rresp;
    logic              rlast;
    logic              bvalid;
    logic [ID_W-1:0]   bid;
    logic [RESP_W-1:0] bresp;
  } axi_resp_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_AR,
    ST_R,
    ST_AW,
    ST_W,
    ST_B,
    ST_DONE
  } bridge_state_t;

endpackage

// File: rtl/cbus_axi_bridge_if.sv
// Bundles the cache-side request/response and the AXI3 master channels seen by the bridge.
interface cbus_axi_bridge_if;
  import cbus_axi_bridge_pkg::*;

  cbus_req_t  creq;
  cbus_resp_t cresp;
  axi_req_t   oreq;
  axi_resp_t  oresp;

  // bridge side
  modport master (input creq, output cresp, output oreq, input oresp);
  // cache + interconnect side
  modport slave (output creq, input cresp, input oreq, output oresp);
endinterface

// File: rtl/cbus_axi_bridge.sv
// Cache bus to AXI3 master bridge: one outstanding read or write burst (up to 16 beats) with
// beat-accurate, in-order cresp handshakes; the final write beat is acknowledged on B completion.
module cbus_axi_bridge
  import cbus_axi_bridge_pkg::*;
#(
  parameter int unsigned        ID_WIDTH = ID_W,
  parameter logic [ID_WIDTH-1:0] AXI_ID  = '0
) (
  input logic              clk,
  input logic              reset,
  cbus_axi_bridge_if.master bus
);

  bridge_state_t      state_q, state_d;
  logic [LEN_W-1:0]   beat_q, beat_d;
  logic [ADDR_W-1:0]  addr_q;
  logic [SIZE_W-1:0]  size_q;
  logic [LEN_W-1:0]   len_q;
  logic [BURST_W-1:0] burst_q;

  axi_req_t   oreq_c;
  cbus_resp_t cresp_c;
  logic       w_final_c;

  assign w_final_c = (beat_q == len_q);

  // State, beat counter and request fields; fields latch on the IDLE accept cycle only.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      beat_q  <= '0;
      addr_q  <= '0;
      size_q  <= '0;
      len_q   <= '0;
      burst_q <= '0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      if (state_q == ST_IDLE && bus.creq.valid) begin
        addr_q  <= bus.creq.addr;
        size_q  <= bus.creq.size;
        len_q   <= bus.creq.len;
        burst_q <= bus.creq.burst;
      end
    end
  end

  // Next state and beat count.
  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    unique case (state_q)
      ST_IDLE: begin
        if (bus.creq.valid) begin
          state_d = bus.creq.is_write ? ST_AW : ST_AR;
          beat_d  = '0;
        end
      end
      ST_AR: begin
        if (bus.oresp.arready) begin
          state_d = ST_R;
          beat_d  = '0;
        end
      end
      ST_R: begin
        if (bus.oresp.rvalid) begin
          if (bus.oresp.rlast) state_d = ST_DONE;
          else                 beat_d  = beat_q + LEN_W'(1);
        end
      end
      ST_AW: begin
        if (bus.oresp.awready) begin
          state_d = ST_W;
          beat_d  = '0;
        end
      end
      ST_W: begin
        if (bus.oresp.wready) begin
          if (w_final_c) state_d = ST_B;
          else           beat_d  = beat_q + LEN_W'(1);
        end
      end
      ST_B: begin
        if (bus.oresp.bvalid) state_d = ST_DONE;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // AXI channel drive and cache acknowledgements; read data and acks pass through in the same cycle.
  always_comb begin
    oreq_c  = '0;
    cresp_c = '0;
    case (state_q)
      ST_AR: begin
        oreq_c.arvalid = 1'b1;
        oreq_c.arid    = ID_W'(AXI_ID);
        oreq_c.araddr  = addr_q;
        oreq_c.arlen   = len_q;
        oreq_c.arsize  = size_q;
        oreq_c.arburst = burst_q;
      end
      ST_R: begin
        oreq_c.rready = 1'b1;
        cresp_c.ready = bus.oresp.rvalid;
        cresp_c.last  = bus.oresp.rvalid & bus.oresp.rlast;
        cresp_c.data  = bus.oresp.rdata;
      end
      ST_AW: begin
        oreq_c.awvalid = 1'b1;
        oreq_c.awid    = ID_W'(AXI_ID);
        oreq_c.awaddr  = addr_q;
        oreq_c.awlen   = len_q;
        oreq_c.awsize  = size_q;
        oreq_c.awburst = burst_q;
      end
      ST_W: begin
        oreq_c.wvalid = 1'b1;
        oreq_c.wid    = ID_W'(AXI_ID);
        oreq_c.wdata  = bus.creq.data;
        oreq_c.wstrb  = bus.creq.strobe;
        oreq_c.wlast  = w_final_c;
        // The last beat is held back until the write response makes it durable.
        cresp_c.ready = bus.oresp.wready & ~w_final_c;
      end
      ST_B: begin
        oreq_c.bready = 1'b1;
        cresp_c.ready = bus.oresp.bvalid;
        cresp_c.last  = bus.oresp.bvalid;
      end
      default: ;
    endcase
  end

  assign bus.oreq  = oreq_c;
  assign bus.cresp = cresp_c;

  // Response codes and IDs carry no information for a single-ID, error-agnostic master.
  logic unused_resp;
  assign unused_resp = ^{bus.oresp.rid, bus.oresp.rresp, bus.oresp.bid, bus.oresp.bresp};

`ifndef SYNTHESIS
  // A read burst whose rlast disagrees with arlen still terminates; flag it here.
  a_rlast_len: assert property (@(posedge clk) disable iff (reset)
      (state_q == ST_R && bus.oresp.rvalid && bus.oresp.rlast) |-> (beat_q == len_q))
    else $error("cbus_axi_bridge: rlast at beat %0d with len %0d", beat_q, len_q);
`endif

endmodule

// File: tb/tb_cbus_axi_bridge.sv
// Directed bench for cbus_axi_bridge: transaction-level expectations plus a per-cycle protocol checker.
module tb_cbus_axi_bridge;
  import cbus_axi_bridge_pkg::*;

  typedef struct { logic [31:0] data; logic last; } beat_t;

  localparam logic [3:0] TB_ID = 4'h5;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  cbus_axi_bridge_if bus ();

  cbus_axi_bridge #(.ID_WIDTH(4), .AXI_ID(TB_ID)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Expected cresp acknowledgements, in order.
  beat_t expq[$];
  beat_t pop_e;

  logic [31:0] exp_addr  = '0;
  logic [3:0]  exp_len   = '0;
  logic [2:0]  exp_size  = '0;
  logic [1:0]  exp_burst = '0;
  logic [3:0]  exp_strb  = '0;

  logic [31:0] rtab [16];
  logic [31:0] wtab [16];
  int          gtab [16] = '{0, 1, 3, 2, 0, 0, 1, 3, 2, 1, 0, 3, 0, 2, 1, 0};

  int cyc = 0, last_cyc = 0, aw_rise_cyc = 0;
  int ar_hs = 0, aw_hs = 0, w_beats = 0, wlast_hs = 0, n_acks = 0;
  logic [31:0] seen_araddr = '0, last_data = '0;
  logic [3:0]  seen_arlen = '0;
  logic pv_ar = 1'b0, pv_arr = 1'b0, pv_aw = 1'b0, pv_awr = 1'b0, pv_w = 1'b0, pv_wr = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h want 0x%0h at t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Per-cycle checker, sampled on the falling edge.
  always @(negedge clk) begin
    if (reset) begin
      pv_ar = 1'b0; pv_arr = 1'b0; pv_aw = 1'b0; pv_awr = 1'b0; pv_w = 1'b0; pv_wr = 1'b0;
    end else begin
      cyc++;
      if (bus.cresp.ready) begin
        chk("cresp_cause", 32'((bus.oresp.rvalid && bus.oreq.rready) ||
                               (bus.oreq.wvalid && bus.oresp.wready && !bus.oreq.wlast) ||
                               (bus.oresp.bvalid && bus.oreq.bready)), 1);
        chk("cresp_expected", 32'(expq.size() > 0), 1);
        if (expq.size() > 0) begin
          pop_e = expq.pop_front();
          chk("cresp_data", bus.cresp.data, pop_e.data);
          chk("cresp_last", 32'(bus.cresp.last), 32'(pop_e.last));
        end
        n_acks++;
        last_data = bus.cresp.data;
        if (bus.cresp.last) last_cyc = cyc;
      end else begin
        chk("cresp_last_idle", 32'(bus.cresp.last), 0);
      end
      if (!bus.oreq.rready) chk("cresp_data_zero", bus.cresp.data, 0);
      if (bus.oreq.arvalid) begin
        chk("ar_aw_excl", 32'({bus.oreq.awvalid, bus.oreq.wvalid}), 0);
        chk("araddr", bus.oreq.araddr, exp_addr);
        chk("arlen", 32'(bus.oreq.arlen), 32'(exp_len));
        chk("arsize", 32'(bus.oreq.arsize), 32'(exp_size));
        chk("arburst", 32'(bus.oreq.arburst), 32'(exp_burst));
        chk("arid", 32'(bus.oreq.arid), 32'(TB_ID));
      end
      if (bus.oreq.awvalid) begin
        chk("aw_w_overlap", 32'(bus.oreq.wvalid), 0);
        chk("awaddr", bus.oreq.awaddr, exp_addr);
        chk("awlen", 32'(bus.oreq.awlen), 32'(exp_len));
        chk("awsize", 32'(bus.oreq.awsize), 32'(exp_size));
        chk("awburst", 32'(bus.oreq.awburst), 32'(exp_burst));
        chk("awid", 32'(bus.oreq.awid), 32'(TB_ID));
      end
      if (bus.oreq.wvalid) begin
        chk("wdata", bus.oreq.wdata, wtab[w_beats % 16]);
        chk("wstrb", 32'(bus.oreq.wstrb), 32'(exp_strb));
        chk("wlast", 32'(bus.oreq.wlast), 32'(w_beats == int'(exp_len)));
        chk("wid", 32'(bus.oreq.wid), 32'(TB_ID));
      end
      if (pv_ar && !pv_arr) chk("arvalid_hold", 32'(bus.oreq.arvalid), 1);
      if (pv_aw && !pv_awr) chk("awvalid_hold", 32'(bus.oreq.awvalid), 1);
      if (pv_w && !pv_wr)   chk("wvalid_hold", 32'(bus.oreq.wvalid), 1);
      if (bus.oreq.awvalid && !pv_aw) aw_rise_cyc = cyc;
      if (bus.oreq.arvalid && bus.oresp.arready) begin
        ar_hs++;
        seen_araddr = bus.oreq.araddr;
        seen_arlen  = bus.oreq.arlen;
      end
      if (bus.oreq.awvalid && bus.oresp.awready) begin
        aw_hs++;
        w_beats = 0;
      end
      if (bus.oreq.wvalid && bus.oresp.wready) begin
        if (bus.oreq.wlast) wlast_hs++;
        w_beats++;
      end
      pv_ar  = bus.oreq.arvalid; pv_arr = bus.oresp.arready;
      pv_aw  = bus.oreq.awvalid; pv_awr = bus.oresp.awready;
      pv_w   = bus.oreq.wvalid;  pv_wr  = bus.oresp.wready;
    end
  end

  task automatic set_req(input logic wr, input logic [31:0] addr, input logic [3:0] len,
                         input logic [3:0] strb, input logic [31:0] data);
    exp_addr = addr; exp_len = len; exp_size = 3'd2; exp_burst = 2'b01; exp_strb = strb;
    bus.creq.valid    = 1'b1;
    bus.creq.is_write = wr;
    bus.creq.size     = 3'd2;
    bus.creq.addr     = addr;
    bus.creq.strobe   = strb;
    bus.creq.data     = data;
    bus.creq.len      = len;
    bus.creq.burst    = 2'b01;
  endtask

  task automatic done_quiet(input string tn);
    #2;
    chk({tn, "_done_quiet"}, 32'({bus.oreq.arvalid, bus.oreq.awvalid, bus.oreq.wvalid,
                                  bus.oreq.rready, bus.oreq.bready, bus.cresp.ready,
                                  bus.cresp.last}), 0);
  endtask

  // Returns in the DONE cycle with creq.valid still high.
  task automatic run_read(input string tn, input logic [31:0] addr, input logic [3:0] len,
                          input int ar_wait, input bit gaps);
    for (int i = 0; i <= int'(len); i++) expq.push_back('{data: rtab[i], last: (i == int'(len))});
    set_req(1'b0, addr, len, 4'hf, 32'h0);
    tick;
    chk({tn, "_ar_latency"}, 32'(bus.oreq.arvalid), 1);
    for (int i = 0; i < ar_wait; i++) tick;
    bus.oresp.arready = 1'b1;
    tick;
    bus.oresp.arready = 1'b0;
    for (int i = 0; i <= int'(len); i++) begin
      if (gaps) for (int g = 0; g < gtab[i]; g++) tick;
      bus.oresp.rvalid = 1'b1;
      bus.oresp.rdata  = rtab[i];
      bus.oresp.rlast  = (i == int'(len));
      #2;
      chk({tn, "_rready"}, 32'(bus.oreq.rready), 1);
      tick;
      bus.oresp.rvalid = 1'b0;
      bus.oresp.rlast  = 1'b0;
      bus.oresp.rdata  = 32'hbad0_0bad;
    end
    done_quiet(tn);
  endtask

  // Returns in the DONE cycle with creq.valid still high.
  task automatic run_write(input string tn, input logic [31:0] addr, input logic [3:0] len,
                           input logic [3:0] strb, input int aw_wait, input bit toggle,
                           input int b_wait);
    int k;
    for (int i = 0; i < int'(len); i++) expq.push_back('{data: 32'h0, last: 1'b0});
    expq.push_back('{data: 32'h0, last: 1'b1});
    set_req(1'b1, addr, len, strb, wtab[0]);
    tick;
    chk({tn, "_aw_latency"}, 32'(bus.oreq.awvalid), 1);
    for (int i = 0; i < aw_wait; i++) tick;
    bus.oresp.awready = 1'b1;
    tick;
    bus.oresp.awready = 1'b0;
    k = 0;
    for (int c = 0; c < 64 && k <= int'(len); c++) begin
      bus.oresp.wready = toggle ? ((c % 2) == 1) : 1'b1;
      bus.creq.data    = wtab[k];
      tick;
      if (bus.oresp.wready) k++;
    end
    bus.oresp.wready = 1'b0;
    chk({tn, "_w_beats"}, k, int'(len) + 1);
    for (int i = 0; i < b_wait; i++) begin
      #2;
      chk({tn, "_bready_hold"}, 32'(bus.oreq.bready), 1);
      chk({tn, "_b_no_ack"}, 32'(bus.cresp.ready), 0);
      tick;
    end
    bus.oresp.bvalid = 1'b1;
    #2;
    chk({tn, "_b_ack"}, 32'({bus.oreq.bready, bus.cresp.ready, bus.cresp.last}), 32'b111);
    tick;
    bus.oresp.bvalid = 1'b0;
    done_quiet(tn);
  endtask

  // Requester drops valid in the cycle after DONE; nothing may be reissued.
  task automatic finish_idle(input string tn);
    tick;
    bus.creq.valid = 1'b0;
    tick;
    #2;
    chk({tn, "_no_reissue"}, 32'({bus.oreq.arvalid, bus.oreq.awvalid}), 0);
    chk({tn, "_drained"}, expq.size(), 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int a0, wl0, ar0, rd_last;
    for (int i = 0; i < 16; i++) begin
      rtab[i] = 32'h0c0f_fee0 + 32'(i * 32'h0101);
      wtab[i] = 32'h5a00_0000 | 32'(i * 17 + 1);
    end
    rtab[0] = 32'hdead_beef;

    // Reset with noisy inputs: everything visible must be quiet.
    bus.creq  = '0;
    bus.oresp = '0;
    bus.creq.valid   = 1'b1;
    bus.oresp.rvalid = 1'b1;
    bus.oresp.rlast  = 1'b1;
    bus.oresp.rdata  = 32'hffff_ffff;
    bus.oresp.bvalid = 1'b1;
    bus.oresp.wready = 1'b1;
    #1 reset = 1'b1;
    repeat (2) @(posedge clk);
    #2;
    chk("rst_valids", 32'({bus.oreq.arvalid, bus.oreq.awvalid, bus.oreq.wvalid, bus.oreq.rready,
                           bus.oreq.bready, bus.cresp.ready, bus.cresp.last}), 0);
    chk("rst_cresp_data", bus.cresp.data, 0);
    bus.creq  = '0;
    bus.oresp = '0;
    tick;
    reset = 1'b0;
    tick;

    // 1: single-beat read, arready after 3 cycles
    a0 = n_acks;
    run_read("t1", 32'h1fc0_0000, 4'd0, 3, 1'b0);
    chk("t1_araddr", seen_araddr, 32'h1fc0_0000);
    chk("t1_data", last_data, 32'hdead_beef);
    chk("t1_acks", n_acks - a0, 1);
    finish_idle("t1");

    // 2: 16-beat read with rvalid gaps
    a0 = n_acks;
    run_read("t2", 32'h8000_1000, 4'd15, 0, 1'b1);
    chk("t2_arlen", 32'(seen_arlen), 15);
    chk("t2_acks", n_acks - a0, 16);
    chk("t2_last_data", last_data, rtab[15]);
    finish_idle("t2");

    // 3: 4-beat write, wready toggling
    a0 = n_acks; wl0 = wlast_hs;
    run_write("t3", 32'h8000_2000, 4'd3, 4'hf, 1, 1'b1, 0);
    chk("t3_acks", n_acks - a0, 4);
    chk("t3_wlast_once", wlast_hs - wl0, 1);
    finish_idle("t3");

    // 4: single-beat write, bvalid 10 cycles late
    a0 = n_acks;
    run_write("t4", 32'h8000_3000, 4'd0, 4'h3, 0, 1'b0, 10);
    chk("t4_acks", n_acks - a0, 1);
    finish_idle("t4");

    // 5: read then write; last handshake on edge k, AW driven from edge k+2 (third sample)
    ar0 = ar_hs;
    run_read("t5r", 32'h8000_4000, 4'd0, 0, 1'b0);
    rd_last = last_cyc;
    tick;
    run_write("t5w", 32'h8000_5000, 4'd0, 4'hf, 0, 1'b0, 0);
    chk("t5_ar_once", ar_hs - ar0, 1);
    chk("t5_aw_gap", aw_rise_cyc - rd_last, 3);
    finish_idle("t5");

    // 6: reset asserted during beat 5 of an 8-beat read
    for (int i = 0; i < 4; i++) expq.push_back('{data: rtab[i], last: 1'b0});
    set_req(1'b0, 32'h2000_0040, 4'd7, 4'hf, 32'h0);
    tick;
    bus.oresp.arready = 1'b1;
    tick;
    bus.oresp.arready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      bus.oresp.rvalid = 1'b1;
      bus.oresp.rdata  = rtab[i];
      tick;
    end
    bus.oresp.rdata = rtab[4];
    #1;
    chk("t6_pre_rst_data", bus.cresp.data, rtab[4]);
    reset = 1'b1;
    #1;
    chk("t6_rst_valids", 32'({bus.oreq.arvalid, bus.oreq.awvalid, bus.oreq.wvalid, bus.oreq.rready,
                              bus.oreq.bready, bus.cresp.ready, bus.cresp.last}), 0);
    chk("t6_rst_data", bus.cresp.data, 0);
    chk("t6_drained_pre", expq.size(), 0);
    expq.delete();
    bus.creq  = '0;
    bus.oresp = '0;
    tick;
    tick;
    reset = 1'b0;
    tick;
    a0 = n_acks;
    run_read("t6", 32'h3000_0000, 4'd1, 1, 1'b0);
    chk("t6_acks", n_acks - a0, 2);
    chk("t6_araddr", seen_araddr, 32'h3000_0000);
    finish_idle("t6");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
